// File: rtl/sipo_pkg.sv
// Shared constants, bank encoding and sizing helper for the SIPO receiver.
package sipo_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_sel_e;

    // At least one bit so the counter port is never zero-width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sipo_holding_bank.sv
// One output holding register with a full flag; a write beats a same-cycle ack.
module sipo_holding_bank
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             ack_i,
    output logic [WIDTH-1:0] word_o,
    output logic             full_o,
    output logic             refused_o
);

    logic [WIDTH-1:0] word_d, word_q;
    logic             full_d, full_q;
    logic             accept;

    // An ack in the same cycle frees the slot in time for the incoming word.
    assign refused_o = wr_i && full_q && !ack_i;
    assign accept    = wr_i && !refused_o;

    always_comb begin
        word_d = word_q;
        full_d = full_q;
        if (ack_i) begin
            full_d = 1'b0;
        end
        if (accept) begin
            word_d = word_i;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            full_q <= 1'b0;
        end else begin
            word_q <= word_d;
            full_q <= full_d;
        end
    end

    assign word_o = word_q;
    assign full_o = full_q;

endmodule

// File: rtl/sipo_shift_register.sv
// Serial-in, parallel-out receiver feeding two alternating holding banks.
module sipo_shift_register
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned CntW     = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ser_in,
    input  logic             shift,
    input  logic             clear,
    input  logic             ack_a,
    input  logic             ack_b,
    output logic [WIDTH-1:0] par_out_a,
    output logic [WIDTH-1:0] par_out_b,
    output logic             full_a,
    output logic             full_b,
    output logic             overrun,
    output logic [CntW-1:0]  bit_count
);

    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_d, sr_q, sr_shifted;
    logic [CntW-1:0]  cnt_d, cnt_q;
    bank_sel_e        bank_sel_d, bank_sel_q;
    logic             overrun_d, overrun_q;
    logic             complete, wr_a, wr_b, refused_a, refused_b, refused;

    always_comb begin
        if (MSB_FIRST) begin
            sr_shifted = {sr_q[WIDTH-2:0], ser_in};
        end else begin
            sr_shifted = {ser_in, sr_q[WIDTH-1:1]};
        end
    end

    assign complete  = shift && !clear && (cnt_q == LastBit);
    assign wr_a      = complete && (bank_sel_q == BANK_A);
    assign wr_b      = complete && (bank_sel_q == BANK_B);
    assign refused   = refused_a || refused_b;
    assign overrun_d = refused;

    always_comb begin
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        bank_sel_d = bank_sel_q;
        if (clear) begin
            sr_d       = '0;
            cnt_d      = '0;
            bank_sel_d = BANK_A;
        end else if (shift) begin
            sr_d  = sr_shifted;
            cnt_d = complete ? '0 : cnt_q + CntW'(1);
            // A dropped word retries the same bank, so the next word stays in order.
            if (complete && !refused) begin
                bank_sel_d = (bank_sel_q == BANK_A) ? BANK_B : BANK_A;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q       <= '0;
            cnt_q      <= '0;
            bank_sel_q <= BANK_A;
            overrun_q  <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            bank_sel_q <= bank_sel_d;
            overrun_q  <= overrun_d;
        end
    end

    sipo_holding_bank #(
        .WIDTH (WIDTH)
    ) u_bank_a (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .wr_i      (wr_a),
        .word_i    (sr_shifted),
        .ack_i     (ack_a),
        .word_o    (par_out_a),
        .full_o    (full_a),
        .refused_o (refused_a)
    );

    sipo_holding_bank #(
        .WIDTH (WIDTH)
    ) u_bank_b (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .wr_i      (wr_b),
        .word_i    (sr_shifted),
        .ack_i     (ack_b),
        .word_o    (par_out_b),
        .full_o    (full_b),
        .refused_o (refused_b)
    );

    assign overrun   = overrun_q;
    assign bit_count = cnt_q;

endmodule

// File: tb/tb_sipo_shift_register.sv
// Scoreboard bench for sipo_shift_register: MSB-first and LSB-first instances.
module tb_sipo_shift_register;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       fa;
        logic       fb;
        logic       ovr;
        logic [2:0] cnt;
    } snap_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       m_ser = 1'b0, m_shift = 1'b0, m_clear = 1'b0, m_ack_a = 1'b0, m_ack_b = 1'b0;
    logic       l_ser = 1'b0, l_shift = 1'b0, l_clear = 1'b0, l_ack_a = 1'b0, l_ack_b = 1'b0;
    logic [7:0] m_pa, m_pb, l_pa, l_pb;
    logic       m_fa, m_fb, m_ovr, l_fa, l_fb, l_ovr;
    logic [2:0] m_cnt, l_cnt;

    snap_t exp_q[$];
    snap_t obs, exp_s;
    int    vectors = 0;
    int    miscompares = 0;

    always #10 clk = ~clk;

    sipo_shift_register #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk       (clk),
        .reset_n   (reset_n),
        .ser_in    (m_ser),
        .shift     (m_shift),
        .clear     (m_clear),
        .ack_a     (m_ack_a),
        .ack_b     (m_ack_b),
        .par_out_a (m_pa),
        .par_out_b (m_pb),
        .full_a    (m_fa),
        .full_b    (m_fb),
        .overrun   (m_ovr),
        .bit_count (m_cnt)
    );

    sipo_shift_register #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk       (clk),
        .reset_n   (reset_n),
        .ser_in    (l_ser),
        .shift     (l_shift),
        .clear     (l_clear),
        .ack_a     (l_ack_a),
        .ack_b     (l_ack_b),
        .par_out_a (l_pa),
        .par_out_b (l_pb),
        .full_a    (l_fa),
        .full_b    (l_fb),
        .overrun   (l_ovr),
        .bit_count (l_cnt)
    );

    function automatic snap_t mk(input logic [7:0] a, input logic [7:0] b, input logic fa,
                                 input logic fb, input logic ovr, input logic [2:0] cnt);
        snap_t s;
        s.a = a; s.b = b; s.fa = fa; s.fb = fb; s.ovr = ovr; s.cnt = cnt;
        return s;
    endfunction

    function automatic snap_t snap_m();
        return mk(m_pa, m_pb, m_fa, m_fb, m_ovr, m_cnt);
    endfunction

    function automatic snap_t snap_l();
        return mk(l_pa, l_pb, l_fa, l_fb, l_ovr, l_cnt);
    endfunction

    function automatic snap_t pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // inst 0 drives the MSB-first instance, inst 1 the LSB-first one.
    task automatic shift_bit(input bit inst, input logic b, input logic clr,
                             input logic aa, input logic ab);
        @(negedge clk);
        if (inst == 1'b0) begin
            m_ser = b; m_shift = 1'b1; m_clear = clr; m_ack_a = aa; m_ack_b = ab;
        end else begin
            l_ser = b; l_shift = 1'b1; l_clear = clr; l_ack_a = aa; l_ack_b = ab;
        end
        @(posedge clk);
        #1;
        m_shift = 1'b0; m_clear = 1'b0; m_ack_a = 1'b0; m_ack_b = 1'b0;
        l_shift = 1'b0; l_clear = 1'b0; l_ack_a = 1'b0; l_ack_b = 1'b0;
    endtask

    // MSB instance sends w[7] first; LSB instance sends w[0] first.
    task automatic send_word(input bit inst, input logic [7:0] w, input bit gap,
                             input logic last_ack_a);
        for (int i = 0; i < 8; i++) begin
            shift_bit(inst, (inst == 1'b0) ? w[7-i] : w[i], 1'b0,
                      (i == 7) ? last_ack_a : 1'b0, 1'b0);
            if (gap && i != 7) idle();
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #4;
        for (int i = 0; i < 4; i++) begin
            m_ser = 1'($urandom); m_shift = 1'($urandom);
            l_ser = 1'($urandom); l_shift = 1'($urandom);
            exp_q.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0));
            exp_q.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0));
            #1;
            obs = snap_m(); exp_s = pop_exp(); vectors++;
            if (obs !== exp_s) begin
                miscompares++;
                $display("FAIL reset_m[%0d]: got %h want %h", i, obs, exp_s);
            end
            obs = snap_l(); exp_s = pop_exp(); vectors++;
            if (obs !== exp_s) begin
                miscompares++;
                $display("FAIL reset_l[%0d]: got %h want %h", i, obs, exp_s);
            end
            #9;
        end
        @(negedge clk);
        m_shift = 1'b0; m_ser = 1'b0; l_shift = 1'b0; l_ser = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_first_word();
        exp_q.push_back(mk(8'hAE, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0));
        send_word(1'b0, 8'hAE, 1'b1, 1'b0);
        obs = snap_m(); exp_s = pop_exp(); vectors++;
        if (obs !== exp_s) begin
            miscompares++;
            $display("FAIL first_word: got %h want %h", obs, exp_s);
        end
    endtask

    task automatic test_alternation_overrun();
        exp_q.push_back(mk(8'hAE, 8'h35, 1'b1, 1'b1, 1'b0, 3'd0));
        send_word(1'b0, 8'h35, 1'b0, 1'b0);
        obs = snap_m(); exp_s = pop_exp(); vectors++;
        if (obs !== exp_s) begin
            miscompares++;
            $display("FAIL alt_bank_b: got %h want %h", obs, exp_s);
        end
        exp_q.push_back(mk(8'hAE, 8'h35, 1'b1, 1'b1, 1'b1, 3'd0));
        send_word(1'b0, 8'h5A, 1'b0, 1'b0);
        obs = snap_m(); exp_s = pop_exp(); vectors++;
        if (obs !== exp_s) begin
            miscompares++;
            $display("FAIL overrun_pulse: got %h want %h", obs, exp_s);
        end
        exp_q.push_back(mk(8'hAE, 8'h35, 1'b1, 1'b1, 1'b0, 3'd0));
        idle();
        obs = snap_m(); exp_s = pop_exp(); vectors++;
        if (obs !== exp_s) begin
            miscompares++;
            $display("FAIL overrun_one_cycle: got %h want %h", obs, exp_s);
        end
        exp_q.push_back(mk(8'hAE, 8'h35, 1'b0, 1'b1, 1'b0, 3'd0));
        @(negedge clk); m_ack_a = 1'b1;
        idle(); m_ack_a = 1'b0;
        obs = snap_m(); exp_s = pop_exp(); vectors++;
        if (obs !== exp_s) begin
            miscompares++;
            $display("FAIL ack_a_clears: got %h want %h", obs, exp_s);
        end
        exp_q.push_back(mk(8'h5A, 8'h35, 1'b1, 1'b1, 1'b0, 3'd0));
        send_word(1'b0, 8'h5A, 1'b0, 1'b0);
        obs = snap_m(); exp_s = pop_exp(); vectors++;
        if (obs !== exp_s) begin
            miscompares++;
            $display("FAIL retry_after_ack: got %h want %h", obs, exp_s);
        end
    endtask

    task automatic test_ack_and_write();
        // Steer back to bank A without touching the banks.
        @(negedge clk); m_clear = 1'b1;
        idle(); m_clear = 1'b0;
        exp_q.push_back(mk(8'hC3, 8'h35, 1'b1, 1'b1, 1'b0, 3'd0));
        send_word(1'b0, 8'hC3, 1'b0, 1'b1);
        obs = snap_m(); exp_s = pop_exp(); vectors++;
        if (obs !== exp_s) begin
            miscompares++;
            $display("FAIL ack_write_same_edge: got %h want %h", obs, exp_s);
        end
        exp_q.push_back(mk(8'hC3, 8'h35, 1'b1, 1'b1, 1'b0, 3'd0));
        idle();
        obs = snap_m(); exp_s = pop_exp(); vectors++;
        if (obs !== exp_s) begin
            miscompares++;
            $display("FAIL ack_write_hold: got %h want %h", obs, exp_s);
        end
    endtask

    task automatic test_clear_mid_word();
        for (int i = 0; i < 3; i++) shift_bit(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(mk(8'hC3, 8'h35, 1'b1, 1'b1, 1'b0, 3'd3));
        obs = snap_m(); exp_s = pop_exp(); vectors++;
        if (obs !== exp_s) begin
            miscompares++;
            $display("FAIL partial_count: got %h want %h", obs, exp_s);
        end
        exp_q.push_back(mk(8'hC3, 8'h35, 1'b0, 1'b1, 1'b0, 3'd0));
        shift_bit(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        obs = snap_m(); exp_s = pop_exp(); vectors++;
        if (obs !== exp_s) begin
            miscompares++;
            $display("FAIL clear_edge: got %h want %h", obs, exp_s);
        end
        exp_q.push_back(mk(8'h81, 8'h35, 1'b1, 1'b1, 1'b0, 3'd0));
        send_word(1'b0, 8'h81, 1'b0, 1'b0);
        obs = snap_m(); exp_s = pop_exp(); vectors++;
        if (obs !== exp_s) begin
            miscompares++;
            $display("FAIL word_after_clear: got %h want %h", obs, exp_s);
        end
    endtask

    task automatic test_lsb_first();
        exp_q.push_back(mk(8'hAE, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0));
        send_word(1'b1, 8'hAE, 1'b0, 1'b0);
        obs = snap_l(); exp_s = pop_exp(); vectors++;
        if (obs !== exp_s) begin
            miscompares++;
            $display("FAIL lsb_first: got %h want %h", obs, exp_s);
        end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_alternation_overrun();
        test_ack_and_write();
        test_clear_mid_word();
        test_lsb_first();
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sipo_shift_register.md
Name: sipo_shift_register

Overview:
Serial-in, parallel-out receiver. It is the far end of the piso_shift_register link: it samples ser_in on each shift strobe and assembles WIDTH-bit words. Completed words go into two holding banks, A and B, used alternately, each with its own full flag and acknowledge. This mirrors the transmitter's par_in_a/par_in_b load pair and lets the consumer drain one word while the next is being received.

Parameters:
WIDTH, 8, word length in bits; must be at least 2
MSB_FIRST, 1, 1 means the first received bit lands in bit WIDTH-1; 0 means it lands in bit 0

Ports:
clk  input  1  system clock (50 MHz); all state changes on the rising edge
reset_n  input  1  asynchronous, active-low reset
ser_in  input  1  serial data; sampled only on edges where shift=1
shift  input  1  sample strobe; one bit is taken per clock with shift=1; strobes need not be contiguous
clear  input  1  synchronous frame restart; discards any partial word
ack_a  input  1  consumer has taken bank A; clears full_a
ack_b  input  1  consumer has taken bank B; clears full_b
par_out_a  output  WIDTH  bank A word
par_out_b  output  WIDTH  bank B word
full_a  output  1  bank A holds an unacknowledged word
full_b  output  1  bank B holds an unacknowledged word
overrun  output  1  one-cycle pulse when a completed word is dropped
bit_count  output  clog2(WIDTH)  bits received in the current word

Behaviour:
- Reset: asynchronous, active-low.
  - While reset_n=0, all outputs are 0.
  - The internal shift register is 0, the bit counter is 0, and bank_sel points to A.
- Shift register update on each edge with shift=1 and clear=0:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], ser_in}.
  - MSB_FIRST=0: sr <= {ser_in, sr[WIDTH-1:1]}.
  - bit_count increments.
- Word completion happens on the shift edge where bit_count==WIDTH-1:
  - The assembled word (including this bit) is formed and bit_count wraps to 0.
  - Target bank is bank_sel. If it is not full, or its ack is asserted in the same cycle:
    - par_out_x takes the word and full_x=1 on that same edge (zero-cycle latency after the last bit).
    - bank_sel toggles.
  - If the target bank is full and not being acked:
    - The word is discarded and par_out_x is unchanged.
    - overrun=1 for exactly one cycle.
    - bank_sel does not toggle.
- ack_x:
  - Clears full_x on the next edge.
  - If a completion writes bank x in the same cycle, the write wins: full_x stays 1 with the new data.
  - An ack while full_x=0 has no effect.
- clear:
  - Zeroes sr and bit_count and sets bank_sel to A.
  - Banks, full flags and par_out are untouched.
  - If clear and shift are both asserted, clear wins and the bit is discarded; no completion occurs even at bit_count==WIDTH-1.
- shift=0 edges: sr and bit_count hold. Gaps of any length between strobes are legal.
- Reset mid-word: the partial word is lost. After release, reception restarts at bit 0 into bank A.
- par_out_x is stable while full_x=1 and changes only on a write to bank x.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Package sipo_pkg holds:
  - the default WIDTH constant;
  - the bank select encoding (BANK_A=0, BANK_B=1);
  - a function computing the counter width.
- One sub-module, sipo_holding_bank, instantiated twice. Each instance holds:
  - the WIDTH-bit word register;
  - the full flag, with write/ack priority (write wins);
  - the write-refused indication used to build overrun.
- The top level owns the shift register, bit counter, bank_sel and the overrun pulse.

Test Plan:
- Reset: hold reset_n=0 for 40 ns with random ser_in and shift. Required: all outputs 0 throughout. After release, the first completed word goes to bank A.
- First word: send 10101110, MSB first, with shift pulsed every other cycle (1 high, 1 low). Required: par_out_a=8'hAE and full_a=1 on the 8th shift edge; bit_count reads 0 afterwards.
- Alternation and overrun:
  - Send 0x35, then 0x5A, with no acks.
  - Required: par_out_b=8'h35 and full_b=1.
  - The third word (0x5A) raises an overrun pulse for one cycle; par_out_a stays 8'hAE.
  - Then assert ack_a and send 0x5A again: par_out_a=8'h5A.
- Simultaneous ack and write: with full_a=1, assert ack_a on the same edge as the final bit of 0xC3 targeting bank A. Required: full_a stays 1, par_out_a=8'hC3, no overrun pulse.
- Clear mid-word: after 3 bits, pulse clear together with a shift. Then send 0x81. Required: par_out_a=8'h81 and bit_count=0 after the clear edge; no stray bits from before the clear.
- MSB_FIRST=0: send bits 0,1,1,1,0,1,0,1 in order. Required: par_out_a=8'hAE.
